// File: rtl/sw_boundary_buffer_if.sv
// Bundles the signals between the last systolic PE, the boundary buffer and
// the replay path into the first PE.
//   master : the side that drives capture/replay control (array controller / bench)
//   slave  : the boundary buffer itself
// Capture side : enable, lock, in_valid, newLineIn, tIn, vIn, fIn, minusAlpha, clear, pop
// Replay side  : newLineOut, tOut, vOut, vOut_alpha, fOut, out_valid
// Status       : full, empty, count, max_score, overflow
interface sw_boundary_buffer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 10
);
  logic             enable;
  logic             lock;
  logic             in_valid;
  logic             newLineIn;
  logic [1:0]       tIn;
  logic [WIDTH-1:0] vIn;
  logic [WIDTH-1:0] fIn;
  logic             pop;
  logic [WIDTH-1:0] minusAlpha;
  logic             clear;

  logic             newLineOut;
  logic [1:0]       tOut;
  logic [WIDTH-1:0] vOut;
  logic [WIDTH-1:0] vOut_alpha;
  logic [WIDTH-1:0] fOut;
  logic             out_valid;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic [WIDTH-1:0] max_score;
  logic             overflow;

  modport master (
    output enable, lock, in_valid, newLineIn, tIn, vIn, fIn, pop, minusAlpha, clear,
    input  newLineOut, tOut, vOut, vOut_alpha, fOut, out_valid,
    input  full, empty, count, max_score, overflow
  );

  modport slave (
    input  enable, lock, in_valid, newLineIn, tIn, vIn, fIn, pop, minusAlpha, clear,
    output newLineOut, tOut, vOut, vOut_alpha, fOut, out_valid,
    output full, empty, count, max_score, overflow
  );
endinterface

// File: rtl/sw_boundary_buffer.sv
// Boundary buffer behind the last PE of the Smith-Waterman systolic array.
// Captures the last PE's per-column stream {newLine, t, V, F} into a circular
// FIFO and replays it (registered, 1-cycle latency) into the first PE on the
// next pass, together with V + minusAlpha. Tracks the running max V pushed.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : sw_boundary_buffer_if.slave (capture inputs, replay outputs, status)
module sw_boundary_buffer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input logic                 clk,
  input logic                 rst,
  sw_boundary_buffer_if.slave bus
);

  localparam int unsigned EW        = 3 + 2 * WIDTH;
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [EW-1:0]    mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             ovf_q, ovf_d;

  logic             nl_q, nl_d;
  logic [1:0]       t_q, t_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] va_q, va_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             valid_q, valid_d;

  logic             empty, full;
  logic             push_req, pop_req, push_ok, pop_ok;
  logic [EW-1:0]    wr_entry, rd_entry;
  logic             rd_nl;
  logic [1:0]       rd_t;
  logic [WIDTH-1:0] rd_v, rd_f;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FullCount);
  assign push_req = bus.enable & ~bus.lock & bus.in_valid;
  assign pop_req  = bus.enable & ~bus.lock & bus.pop;
  // clear wins the cycle; a pop on empty is ignored even if a push lands (no bypass).
  assign pop_ok   = pop_req & ~empty & ~bus.clear;
  // When full, a push only fits if the head leaves in the same cycle.
  assign push_ok  = push_req & (~full | pop_ok) & ~bus.clear;

  assign wr_entry = {bus.newLineIn, bus.tIn, bus.vIn, bus.fIn};
  assign rd_entry = mem_q[rd_ptr_q];
  assign {rd_nl, rd_t, rd_v, rd_f} = rd_entry;

  // Storage: one write port, one read port feeding the output registers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    max_d    = max_q;
    ovf_d    = ovf_q;
    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      max_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (bus.vIn > max_q) begin
          max_d = bus.vIn;
        end
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
      if (push_req && full && !pop_req) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_comb begin
    nl_d    = nl_q;
    t_d     = t_q;
    v_d     = v_q;
    va_d    = va_q;
    f_d     = f_q;
    valid_d = 1'b0;
    if (!bus.enable) begin
      nl_d = 1'b0;
      t_d  = '0;
      v_d  = '0;
      va_d = '0;
      f_d  = '0;
    end else if (bus.clear) begin
      valid_d = 1'b0;
    end else if (bus.lock) begin
      // Array stalled: freeze everything, including the valid flag.
      valid_d = valid_q;
    end else if (pop_ok) begin
      nl_d    = rd_nl;
      t_d     = rd_t;
      v_d     = rd_v;
      va_d    = rd_v + bus.minusAlpha;
      f_d     = rd_f;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      max_q    <= '0;
      ovf_q    <= 1'b0;
      nl_q     <= 1'b0;
      t_q      <= '0;
      v_q      <= '0;
      va_q     <= '0;
      f_q      <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      max_q    <= max_d;
      ovf_q    <= ovf_d;
      nl_q     <= nl_d;
      t_q      <= t_d;
      v_q      <= v_d;
      va_q     <= va_d;
      f_q      <= f_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.newLineOut = nl_q;
  assign bus.tOut       = t_q;
  assign bus.vOut       = v_q;
  assign bus.vOut_alpha = va_q;
  assign bus.fOut       = f_q;
  assign bus.out_valid  = valid_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.count      = count_q;
  assign bus.max_score  = max_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_sw_boundary_buffer.sv
// Self-checking bench for sw_boundary_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_sw_boundary_buffer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  typedef struct packed {
    logic             nl;
    logic [1:0]       t;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] f;
  } ent_t;

  logic clk;
  logic rst;

  sw_boundary_buffer_if #(.WIDTH(WIDTH), .AW(AW)) bif ();

  sw_boundary_buffer #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  ent_t             q[$];
  logic             m_nl;
  logic [1:0]       m_t;
  logic [WIDTH-1:0] m_v, m_va, m_f, m_max;
  logic             m_valid, m_ovf;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_nl = 0; m_t = 0; m_v = 0; m_va = 0; m_f = 0;
    m_max = 0; m_valid = 0; m_ovf = 0;
  endtask

  // Applies the inputs present at this clock edge to the model.
  task automatic model_step();
    ent_t head;
    ent_t e;
    bit   do_pop;
    bit   do_push;
    int   sz;
    sz      = q.size();
    do_pop  = 0;
    do_push = 0;
    if (bif.enable && !bif.lock && !bif.clear) begin
      do_pop  = bif.pop && (sz > 0);
      do_push = bif.in_valid && ((sz < int'(DEPTH)) || do_pop);
      if (bif.in_valid && (sz == int'(DEPTH)) && !bif.pop) m_ovf = 1;
    end
    if (do_pop) head = q.pop_front();
    if (!bif.enable) begin
      m_nl = 0; m_t = 0; m_v = 0; m_va = 0; m_f = 0; m_valid = 0;
    end else if (bif.clear) begin
      m_valid = 0;
    end else if (!bif.lock) begin
      m_valid = do_pop;
      if (do_pop) begin
        m_nl = head.nl; m_t = head.t; m_v = head.v; m_f = head.f;
        m_va = head.v + bif.minusAlpha;
      end
    end
    if (do_push) begin
      e.nl = bif.newLineIn; e.t = bif.tIn; e.v = bif.vIn; e.f = bif.fIn;
      q.push_back(e);
      if (bif.vIn > m_max) m_max = bif.vIn;
    end
    if (bif.clear) begin
      q.delete();
      m_max = 0;
      m_ovf = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".valid"}, 32'(bif.out_valid), 32'(m_valid));
    check_val({tag, ".v"}, 32'(bif.vOut), 32'(m_v));
    check_val({tag, ".va"}, 32'(bif.vOut_alpha), 32'(m_va));
    check_val({tag, ".f"}, 32'(bif.fOut), 32'(m_f));
    check_val({tag, ".t"}, 32'(bif.tOut), 32'(m_t));
    check_val({tag, ".nl"}, 32'(bif.newLineOut), 32'(m_nl));
    check_val({tag, ".count"}, 32'(bif.count), 32'(q.size()));
    check_val({tag, ".empty"}, 32'(bif.empty), 32'(q.size() == 0));
    check_val({tag, ".full"}, 32'(bif.full), 32'(q.size() == int'(DEPTH)));
    check_val({tag, ".max"}, 32'(bif.max_score), 32'(m_max));
    check_val({tag, ".ovf"}, 32'(bif.overflow), 32'(m_ovf));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input string tag, input logic iv, input logic p,
                       input logic [WIDTH-1:0] v, input logic nl);
    bif.in_valid  = iv;
    bif.pop       = p;
    bif.vIn       = v;
    bif.newLineIn = nl;
    bif.tIn       = v[1:0];
    bif.fIn       = v ^ 16'h5a5a;
    tick(tag);
  endtask

  logic [WIDTH-1:0] exp_v  [4];
  logic [WIDTH-1:0] exp_va [4];
  logic             exp_nl [4];

  initial begin
    rst            = 1'b1;
    bif.enable     = 1'b1;
    bif.lock       = 1'b0;
    bif.in_valid   = 1'b0;
    bif.newLineIn  = 1'b0;
    bif.tIn        = '0;
    bif.vIn        = '0;
    bif.fIn        = '0;
    bif.pop        = 1'b0;
    bif.minusAlpha = '0;
    bif.clear      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Mid-operation async reset
    for (int i = 0; i < 4; i++) drive("pre_rst", 1, 0, 16'(100 + i), 0);
    drive("pre_rst_pop", 0, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check_val("async_rst.count0", 32'(bif.count), 32'd0);
    #1;
    rst = 1'b0;

    // Stream and replay with minusAlpha = -2
    bif.minusAlpha = 16'hFFFE;
    exp_v[0] = 3; exp_v[1] = 9; exp_v[2] = 2; exp_v[3] = 7;
    exp_va[0] = 1; exp_va[1] = 7; exp_va[2] = 0; exp_va[3] = 5;
    exp_nl[0] = 1; exp_nl[1] = 0; exp_nl[2] = 0; exp_nl[3] = 0;
    for (int i = 0; i < 4; i++) drive("stream_push", 1, 0, exp_v[i], (i == 0));
    for (int i = 0; i < 4; i++) begin
      drive("stream_pop", 0, 1, 0, 0);
      check_val("stream.v", 32'(bif.vOut), 32'(exp_v[i]));
      check_val("stream.va", 32'(bif.vOut_alpha), 32'(exp_va[i]));
      check_val("stream.nl", 32'(bif.newLineOut), 32'(exp_nl[i]));
      check_val("stream.valid", 32'(bif.out_valid), 32'd1);
    end
    drive("stream_idle", 0, 0, 0, 0);
    check_val("stream.max", 32'(bif.max_score), 32'd9);

    // Full and overflow
    for (int i = 0; i < 5; i++) begin
      drive("ovf_push", 1, 0, 16'(20 + i), 0);
      if (i == 3) check_val("ovf.full4", 32'(bif.full), 32'd1);
    end
    check_val("ovf.flag", 32'(bif.overflow), 32'd1);
    check_val("ovf.count", 32'(bif.count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive("ovf_pop", 0, 1, 0, 0);
      check_val("ovf.pop_v", 32'(bif.vOut), 32'(20 + i));
    end
    bif.clear = 1'b1;
    drive("clear1", 0, 0, 0, 0);
    bif.clear = 1'b0;
    check_val("clear1.ovf", 32'(bif.overflow), 32'd0);

    // Simultaneous push and pop at full
    for (int i = 0; i < 4; i++) drive("sim_fill", 1, 0, 16'(30 + i), 0);
    drive("sim_pp", 1, 1, 16'd11, 0);
    check_val("sim.v", 32'(bif.vOut), 32'd30);
    check_val("sim.count", 32'(bif.count), 32'd4);
    check_val("sim.ovf", 32'(bif.overflow), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive("sim_pop", 0, 1, 0, 0);
      check_val("sim.pop_v", 32'(bif.vOut), 32'(31 + i));
    end
    drive("sim_pop11", 0, 1, 0, 0);
    check_val("sim.v11", 32'(bif.vOut), 32'd11);

    // Lock, then pop on empty
    drive("lk_push", 1, 0, 16'd50, 0);
    drive("lk_push", 1, 0, 16'd51, 0);
    drive("lk_pop", 0, 1, 0, 0);
    bif.lock = 1'b1;
    drive("lock", 1, 1, 16'd55, 1);
    check_val("lock.count", 32'(bif.count), 32'd1);
    check_val("lock.v", 32'(bif.vOut), 32'd50);
    bif.lock = 1'b0;
    drive("lk_pop2", 0, 1, 0, 0);
    drive("empty_pop", 0, 1, 0, 0);
    check_val("empty_pop.valid", 32'(bif.out_valid), 32'd0);
    drive("empty_pp", 1, 1, 16'd60, 0);
    check_val("empty_pp.count", 32'(bif.count), 32'd1);
    drive("drain", 0, 1, 0, 0);

    // Wrap: six entries through a four-deep ring
    drive("wrap_push", 1, 0, 16'd40, 0);
    drive("wrap_push", 1, 0, 16'd41, 0);
    drive("wrap_push", 1, 0, 16'd42, 0);
    for (int i = 0; i < 3; i++) begin
      drive("wrap_pp", 1, 1, 16'(43 + i), 0);
      check_val("wrap.v", 32'(bif.vOut), 32'(40 + i));
    end
    for (int i = 0; i < 3; i++) begin
      drive("wrap_pop", 0, 1, 0, 0);
      check_val("wrap.v", 32'(bif.vOut), 32'(43 + i));
    end
    drive("wrap_push2", 1, 0, 16'd70, 0);
    bif.clear = 1'b1;
    drive("clear2", 1, 1, 16'd90, 0);
    bif.clear = 1'b0;
    check_val("clear2.count", 32'(bif.count), 32'd0);
    check_val("clear2.max", 32'(bif.max_score), 32'd0);

    // Enable low zeroes the replay outputs
    drive("en_fill", 1, 0, 16'd77, 1);
    drive("en_pop", 0, 1, 0, 0);
    bif.enable = 1'b0;
    drive("disable", 1, 1, 16'd5, 0);
    check_val("disable.v", 32'(bif.vOut), 32'd0);
    bif.enable = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bif.enable     = ($urandom_range(0, 7) != 0);
      bif.lock       = ($urandom_range(0, 7) == 0);
      bif.clear      = ($urandom_range(0, 39) == 0);
      bif.minusAlpha = 16'($urandom);
      drive("rand", ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 5),
            16'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
